pwm_fade_sequencer: RTL and testbench

- Controller that sequences the duty-cycle and period settings of the PWM core.
- Two operating modes:
  - Fade: ramps the duty cycle to a target at a programmable step per time-base tick.
  - Breathe: auto-triangles the duty cycle between min and max, with hold plateaus.
- Sits between the switch/host configuration and the PWM core. Its tick input is the millisecond strobe from the clock divider.
- New settings are committed to the core only at PWM cycle boundaries, so the output never glitches.

---
 rtl/pwm_fade_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_sequencer.sv
// Purpose: sequences PWM duty/period: fade-to-target or min/max breathe with hold plateaus.
// Latency: duty_acc steps on the tick edge; the core sees it at the next cycle_end after that edge.
// Backpressure: none; enable=0 freezes the ramp while shadow commits to the core keep running.
module pwm_fade_sequencer #(
    parameter int N      = 8,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    input  logic              breathe,
    input  logic [N-1:0]      target,
    input  logic [N-1:0]      duty_min,
    input  logic [N-1:0]      duty_max,
    input  logic [N-1:0]      step,
    input  logic [HOLD_W-1:0] hold_ticks,
    input  logic [N:0]        period_in,
    input  logic              cycle_end,
    output logic [N-1:0]      duty_out,
    output logic [N:0]        period_out,
    output logic              load,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        DOWN    = 3'd2,
        HOLD_HI = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      duty_acc_q, duty_acc_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pending_q, pending_d;
    logic [N-1:0]      duty_out_q, duty_out_d;
    logic [N:0]        period_out_q, period_out_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Ramp arithmetic: a zero step would stall forever, so it behaves as 1.
    logic [N-1:0]        step_eff;
    logic [N-1:0]        up_lim;
    logic [N-1:0]        dn_lim;
    logic [N:0]          up_sum;
    logic signed [N+1:0] dn_diff;
    logic [N-1:0]        up_next;
    logic [N-1:0]        dn_next;
    logic [HOLD_W-1:0]   hold_inc;
    logic                range_bad;

    assign step_eff  = (step == '0) ? N'(1) : step;
    assign up_lim    = breathe ? duty_max : target;
    assign dn_lim    = breathe ? duty_min : target;
    assign up_sum    = {1'b0, duty_acc_q} + {1'b0, step_eff};
    assign dn_diff   = $signed({2'b00, duty_acc_q}) - $signed({2'b00, step_eff});
    // Saturate at the limit: the extra bit catches overflow, the sign catches underflow.
    assign up_next   = (up_sum >= {1'b0, up_lim}) ? up_lim : up_sum[N-1:0];
    assign dn_next   = (dn_diff <= $signed({2'b00, dn_lim})) ? dn_lim : dn_diff[N-1:0];
    assign hold_inc  = hold_cnt_q + HOLD_W'(1);
    assign range_bad = (duty_min >= duty_max);

    // Next-state and ramp accumulator: IDLE decides on any clk, all other moves wait for tick.
    always_comb begin
        state_d    = state_q;
        duty_acc_d = duty_acc_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
        end else if (state_q == IDLE) begin
            hold_cnt_d = '0;
            if (breathe) begin
                state_d = (duty_acc_q < duty_max) ? UP : DOWN;
            end else if (target > duty_acc_q) begin
                state_d = UP;
            end else if (target < duty_acc_q) begin
                state_d = DOWN;
            end
        end else if (tick) begin
            if (!breathe) begin
                // Fade: re-aim at the current target every tick, whichever side it is on.
                hold_cnt_d = '0;
                if (target > duty_acc_q) begin
                    duty_acc_d = up_next;
                    if (up_next == target) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = UP;
                    end
                end else if (target < duty_acc_q) begin
                    duty_acc_d = dn_next;
                    if (dn_next == target) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DOWN;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else if (range_bad) begin
                // Empty breathe window: pin to the max and park.
                duty_acc_d = duty_max;
                hold_cnt_d = '0;
                state_d    = HOLD_HI;
            end else begin
                case (state_q)
                    UP: begin
                        duty_acc_d = up_next;
                        if (up_next == duty_max) begin
                            hold_cnt_d = '0;
                            state_d    = (hold_ticks == '0) ? DOWN : HOLD_HI;
                        end
                    end
                    DOWN: begin
                        duty_acc_d = dn_next;
                        if (dn_next == duty_min) begin
                            hold_cnt_d = '0;
                            state_d    = (hold_ticks == '0) ? UP : HOLD_LO;
                        end
                    end
                    HOLD_HI: begin
                        if (hold_inc >= hold_ticks) begin
                            hold_cnt_d = '0;
                            state_d    = DOWN;
                        end else begin
                            hold_cnt_d = hold_inc;
                        end
                    end
                    HOLD_LO: begin
                        if (hold_inc >= hold_ticks) begin
                            hold_cnt_d = '0;
                            state_d    = UP;
                        end else begin
                            hold_cnt_d = hold_inc;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Shadow commit: hand the pre-edge duty_acc/period_in to the core only at a period boundary.
    always_comb begin
        load_d       = 1'b0;
        duty_out_d   = duty_out_q;
        period_out_d = period_out_q;
        if (cycle_end && pending_q) begin
            duty_out_d   = duty_acc_q;
            period_out_d = period_in;
            load_d       = 1'b1;
        end
        // Looking at next-cycle values keeps a just-committed setting from loading twice,
        // and keeps a same-edge duty change pending for the following boundary.
        pending_d = (duty_acc_d != duty_out_d) || (period_in != period_out_d);
        busy_d    = (state_q != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            duty_acc_q   <= '0;
            hold_cnt_q   <= '0;
            pending_q    <= 1'b0;
            duty_out_q   <= '0;
            period_out_q <= '0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_acc_q   <= duty_acc_d;
            hold_cnt_q   <= hold_cnt_d;
            pending_q    <= pending_d;
            duty_out_q   <= duty_out_d;
            period_out_q <= period_out_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign duty_out   = duty_out_q;
    assign period_out = period_out_q;
    assign load       = load_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Purpose: directed checks of fade, breathe, freeze and shadow-commit behaviour.
// Latency: outputs sampled 1ns after the rising edge that produced them.
// Backpressure: none; all waits are fixed cycle counts.
module tb_pwm_fade_sequencer;

    localparam int N      = 8;
    localparam int HOLD_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic              enable = 1'b0;
    logic              breathe = 1'b0;
    logic [N-1:0]      target = '0;
    logic [N-1:0]      duty_min = '0;
    logic [N-1:0]      duty_max = '0;
    logic [N-1:0]      step = '0;
    logic [HOLD_W-1:0] hold_ticks = '0;
    logic [N:0]        period_in = '0;
    logic              cycle_end = 1'b0;
    logic [N-1:0]      duty_out;
    logic [N:0]        period_out;
    logic              load;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int load_cnt = 0;

    pwm_fade_sequencer #(.N(N), .HOLD_W(HOLD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .enable     (enable),
        .breathe    (breathe),
        .target     (target),
        .duty_min   (duty_min),
        .duty_max   (duty_max),
        .step       (step),
        .hold_ticks (hold_ticks),
        .period_in  (period_in),
        .cycle_end  (cycle_end),
        .duty_out   (duty_out),
        .period_out (period_out),
        .load       (load),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (load) load_cnt = load_cnt + 1;
    end

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick;
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic apply_reset;
        reset = 1'b1; enable = 1'b0; tick = 1'b0; cycle_end = 1'b0; breathe = 1'b0;
        clk1();
        clk1();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        period_in = 9'd200;
        target    = 8'd100;
        reset = 1'b1; enable = 1'b0; tick = 1'b0; cycle_end = 1'b0;
        clk1();
        clk1();
        total++; if ({duty_out, period_out, load, busy, done} !== '0) begin bad++;
            $display("FAIL reset_outputs: duty=%0d period=%0d load=%b busy=%b done=%b want all 0",
                     duty_out, period_out, load, busy, done); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk1();
            total++; if ({duty_out, period_out, load, busy} !== '0) begin bad++;
                $display("FAIL reset_hold[%0d]: duty=%0d period=%0d load=%b busy=%b want all 0",
                         i, duty_out, period_out, load, busy); end
        end
    endtask

    task automatic test_fade;
        int exp_duty[4];
        int l0, d0;
        exp_duty = '{30, 60, 90, 100};
        cycle_end = 1'b1;
        clk1(); clk1(); clk1();
        total++; if (period_out !== 9'd200) begin bad++;
            $display("FAIL fade_period: got %0d want 200", period_out); end
        l0 = load_cnt; d0 = done_cnt;
        step = 8'd30; target = 8'd100; enable = 1'b1;
        clk1();
        for (int i = 0; i < 4; i++) begin
            do_tick();
            total++; if (done !== (i == 3)) begin bad++;
                $display("FAIL fade_done[%0d]: got %b want %b", i, done, (i == 3)); end
            if (i == 3) begin
                total++; if (busy !== 1'b1) begin bad++;
                    $display("FAIL fade_busy_at_done: got %b want 1", busy); end
            end
            clk1();
            total++; if (duty_out !== 8'(exp_duty[i])) begin bad++;
                $display("FAIL fade_duty[%0d]: got %0d want %0d", i, duty_out, exp_duty[i]); end
            if (i == 3) begin
                total++; if (busy !== 1'b0) begin bad++;
                    $display("FAIL fade_busy_after_done: got %b want 0", busy); end
            end
            clk1(); clk1();
        end
        total++; if (load_cnt - l0 !== 4) begin bad++;
            $display("FAIL fade_loads: got %0d want 4", load_cnt - l0); end
        total++; if (done_cnt - d0 !== 1) begin bad++;
            $display("FAIL fade_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_step_zero;
        apply_reset();
        cycle_end = 1'b1; target = 8'd3; step = 8'd0; enable = 1'b1;
        clk1();
        for (int i = 0; i < 3; i++) begin
            do_tick();
            total++; if (done !== (i == 2)) begin bad++;
                $display("FAIL step0_done[%0d]: got %b want %b", i, done, (i == 2)); end
            clk1();
            total++; if (duty_out !== 8'(i + 1)) begin bad++;
                $display("FAIL step0_duty[%0d]: got %0d want %0d", i, duty_out, i + 1); end
        end
    endtask

    task automatic test_underflow;
        target = 8'd5; step = 8'd2;
        clk1();
        do_tick();
        clk1();
        total++; if (duty_out !== 8'd5) begin bad++;
            $display("FAIL underflow_setup: got %0d want 5", duty_out); end
        target = 8'd0; step = 8'd200;
        clk1();
        do_tick();
        total++; if (done !== 1'b1) begin bad++;
            $display("FAIL underflow_done: got %b want 1", done); end
        clk1();
        total++; if (duty_out !== 8'd0) begin bad++;
            $display("FAIL underflow_duty: got %0d want 0", duty_out); end
    endtask

    task automatic test_enable_freeze;
        int d0;
        apply_reset();
        cycle_end = 1'b1; target = 8'd100; step = 8'd30; enable = 1'b1;
        clk1();
        do_tick(); do_tick();
        clk1();
        total++; if (duty_out !== 8'd60) begin bad++;
            $display("FAIL freeze_pre: got %0d want 60", duty_out); end
        enable = 1'b0;
        clk1();
        d0 = done_cnt;
        do_tick();
        clk1(); clk1();
        total++; if (duty_out !== 8'd60) begin bad++;
            $display("FAIL freeze_hold: got %0d want 60", duty_out); end
        total++; if (busy !== 1'b0) begin bad++;
            $display("FAIL freeze_busy: got %b want 0", busy); end
        enable = 1'b1;
        clk1();
        do_tick();
        clk1();
        total++; if (duty_out !== 8'd90) begin bad++;
            $display("FAIL freeze_resume1: got %0d want 90", duty_out); end
        do_tick();
        total++; if (done !== 1'b1) begin bad++;
            $display("FAIL freeze_done: got %b want 1", done); end
        clk1();
        total++; if (duty_out !== 8'd100) begin bad++;
            $display("FAIL freeze_resume2: got %0d want 100", duty_out); end
        total++; if (done_cnt - d0 !== 1) begin bad++;
            $display("FAIL freeze_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_same_edge;
        period_in = 9'd0;
        apply_reset();
        target = 8'd100; step = 8'd30; enable = 1'b1;
        clk1();
        do_tick();
        clk1();
        cycle_end = 1'b1;
        do_tick();
        total++; if (duty_out !== 8'd30 || load !== 1'b1) begin bad++;
            $display("FAIL same_edge_old: duty=%0d load=%b want 30/1", duty_out, load); end
        cycle_end = 1'b0;
        clk1();
        total++; if (duty_out !== 8'd30) begin bad++;
            $display("FAIL same_edge_wait: got %0d want 30", duty_out); end
        cycle_end = 1'b1;
        clk1();
        total++; if (duty_out !== 8'd60 || load !== 1'b1) begin bad++;
            $display("FAIL same_edge_new: duty=%0d load=%b want 60/1", duty_out, load); end
        clk1();
        total++; if (load !== 1'b0) begin bad++;
            $display("FAIL same_edge_idle_load: got %b want 0", load); end
        cycle_end = 1'b0;
    endtask

    task automatic test_breathe;
        int exp_duty[9];
        int d0;
        exp_duty = '{25, 40, 40, 40, 25, 10, 10, 10, 25};
        period_in = 9'd0;
        apply_reset();
        cycle_end = 1'b1; target = 8'd10; step = 8'd10; enable = 1'b1;
        clk1();
        do_tick();
        clk1();
        d0 = done_cnt;
        breathe = 1'b1; duty_min = 8'd10; duty_max = 8'd40; step = 8'd15; hold_ticks = 8'd2;
        clk1();
        for (int i = 0; i < 9; i++) begin
            do_tick();
            clk1();
            total++; if (duty_out !== 8'(exp_duty[i])) begin bad++;
                $display("FAIL breathe_duty[%0d]: got %0d want %0d", i, duty_out, exp_duty[i]); end
        end
        total++; if (done_cnt !== d0) begin bad++;
            $display("FAIL breathe_no_done: got %0d pulses want 0", done_cnt - d0); end
        duty_min = 8'd50; duty_max = 8'd20;
        do_tick();
        clk1();
        total++; if (duty_out !== 8'd20) begin bad++;
            $display("FAIL breathe_degenerate: got %0d want 20", duty_out); end
        do_tick();
        clk1();
        total++; if (duty_out !== 8'd20 || busy !== 1'b1) begin bad++;
            $display("FAIL breathe_parked: duty=%0d busy=%b want 20/1", duty_out, busy); end
        breathe = 1'b0; target = 8'd50; step = 8'd30;
        do_tick();
        total++; if (done !== 1'b1) begin bad++;
            $display("FAIL mode_switch_done: got %b want 1", done); end
        clk1();
        total++; if (duty_out !== 8'd50) begin bad++;
            $display("FAIL mode_switch_duty: got %0d want 50", duty_out); end
    endtask

    initial begin
        test_reset();
        test_fade();
        test_step_zero();
        test_underflow();
        test_enable_freeze();
        test_same_edge();
        test_breathe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
